// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: double-buffered 16-bit L/R pairs serialized MSB first, one-bit delay after LRCLK.
// state | meaning:  IDLE | link quiet, waiting for first pair;  RUN | free-running 64-bit frames
module i2s_tx #(
  parameter int SCLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rht_smpl,
  input  logic        smpl_vld,
  output logic        sclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        smpl_req,
  output logic        underrun,
  output logic        active
);

  localparam int CW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] CLK_HALF = CW'(SCLK_DIV / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic          hold_vld_q, hold_vld_d;
  logic [15:0]   sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic          sclk_q, sclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic          smpl_req_q, smpl_req_d, underrun_q, underrun_d, active_q, active_d;

  logic          clk_wrap, frame_wrap;
  logic [4:0]    slot, bit_idx;
  logic [15:0]   word;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    hold_vld_d = hold_vld_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;
    smpl_req_d = 1'b0;
    underrun_d = 1'b0;
    clk_wrap   = (clk_cnt_q == CLK_LAST);
    frame_wrap = clk_wrap && (bit_cnt_q == 6'd63);

    case (state_q)
      IDLE: begin
        if (smpl_vld) begin
          state_d    = RUN;
          sh_l_d     = lft_smpl;
          sh_r_d     = rht_smpl;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          smpl_req_d = 1'b1;
        end
      end
      RUN: begin
        clk_cnt_d = clk_wrap ? '0 : clk_cnt_q + CW'(1);
        if (clk_wrap) bit_cnt_d = bit_cnt_q + 6'd1;
        if (frame_wrap) begin
          if (hold_vld_q) begin
            sh_l_d     = hold_l_q;
            sh_r_d     = hold_r_q;
            smpl_req_d = 1'b1;
            hold_vld_d = smpl_vld;
            if (smpl_vld) begin
              hold_l_d = lft_smpl;
              hold_r_d = rht_smpl;
            end
          end else if (smpl_vld) begin
            // pair arriving exactly at the boundary skips the holding register
            sh_l_d     = lft_smpl;
            sh_r_d     = rht_smpl;
            smpl_req_d = 1'b1;
          end else begin
            sh_l_d     = '0;
            sh_r_d     = '0;
            underrun_d = 1'b1;
          end
        end else if (smpl_vld) begin
          hold_l_d   = lft_smpl;
          hold_r_d   = rht_smpl;
          hold_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // outputs are derived from next-state counters so the pins are pure flops
    slot     = bit_cnt_d[4:0];
    bit_idx  = 5'd16 - slot;
    word     = bit_cnt_d[5] ? sh_r_d : sh_l_d;
    active_d = (state_d == RUN);
    sclk_d   = active_d && (clk_cnt_d >= CLK_HALF);
    lrclk_d  = active_d && bit_cnt_d[5];
    sdata_d  = 1'b0;
    if (active_d && (slot >= 5'd1) && (slot <= 5'd16)) sdata_d = word[bit_idx[3:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      hold_vld_q <= 1'b0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      smpl_req_q <= 1'b0;
      underrun_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      hold_vld_q <= hold_vld_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      smpl_req_q <= smpl_req_d;
      underrun_q <= underrun_d;
      active_q   <= active_d;
    end
  end

  assign sclk     = sclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign smpl_req = smpl_req_q;
  assign underrun = underrun_q;
  assign active   = active_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a negedge monitor reassembles frames from sdata at sclk rises,
// the main sequence drives pairs from a vector table and checks frame contents and pulses.
module tb_i2s_tx;
  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] lft_smpl, rht_smpl;
  logic        smpl_vld;
  logic        sclk, lrclk, sdata, smpl_req, underrun, active;

  i2s_tx #(.SCLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .lft_smpl(lft_smpl), .rht_smpl(rht_smpl), .smpl_vld(smpl_vld),
    .sclk(sclk), .lrclk(lrclk), .sdata(sdata), .smpl_req(smpl_req), .underrun(underrun),
    .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          nz;
    int          lrerr;
    logic        und;
  } frame_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        exp_req;
    logic        exp_und;
  } vec_t;

  frame_t fq[$];
  frame_t cur;
  int     n_chk = 0, n_fail = 0;
  int     ncyc = 0, k = 0, rise_cyc = 0, lr_cyc = 0;
  int     sclk_err = 0, lr_err = 0, n_lr = 0;
  bit     in_frame = 0, have_rise = 0, have_lr = 0, prev_sclk = 0, prev_lr = 0;

  // frame reassembly and sclk/lrclk period measurement
  always @(negedge clk) begin
    ncyc++;
    if (!active) begin
      in_frame = 0; have_rise = 0; have_lr = 0; prev_sclk = 0; prev_lr = 0;
    end else begin
      if (smpl_req || underrun) begin
        in_frame = 1; k = 0;
        cur.l = '0; cur.r = '0; cur.nz = 0; cur.lrerr = 0; cur.und = underrun;
      end
      if (sclk && !prev_sclk) begin
        if (have_rise && (ncyc - rise_cyc) != DIV) sclk_err++;
        rise_cyc = ncyc; have_rise = 1;
        if (in_frame) begin
          if (lrclk != (k >= 32)) cur.lrerr++;
          if (k >= 1 && k <= 16) cur.l[16-k] = sdata;
          else if (k >= 33 && k <= 48) cur.r[48-k] = sdata;
          else if (sdata) cur.nz++;
          k++;
          if (k == 64) begin fq.push_back(cur); in_frame = 0; end
        end
      end
      if (!sclk && prev_sclk && have_rise && (ncyc - rise_cyc) != DIV/2) sclk_err++;
      if (lrclk && !prev_lr) begin
        if (have_lr && (ncyc - lr_cyc) != 64*DIV) lr_err++;
        lr_cyc = ncyc; have_lr = 1; n_lr++;
      end
      prev_sclk = sclk; prev_lr = lrclk;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_pair(input logic [15:0] l, input logic [15:0] r);
    lft_smpl = l; rht_smpl = r; smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
  endtask

  task automatic wait_fs(output logic req, output logic und);
    int n = 0;
    do begin tick(); n++; end while (!(smpl_req || underrun) && n < 1100);
    chk("frame_start_seen", 32'(smpl_req || underrun), 1);
    req = smpl_req; und = underrun;
  endtask

  task automatic pop_frame(input string tag, input logic [15:0] el, input logic [15:0] er,
                           input logic eund);
    frame_t f;
    chk({tag, "_avail"}, 32'(fq.size() > 0), 1);
    if (fq.size() == 0) return;
    f = fq.pop_front();
    chk({tag, "_left"}, 32'(f.l), 32'(el));
    chk({tag, "_right"}, 32'(f.r), 32'(er));
    chk({tag, "_idle_slots"}, f.nz, 0);
    chk({tag, "_lrclk"}, f.lrerr, 0);
    chk({tag, "_underrun_start"}, 32'(f.und), 32'(eund));
  endtask

  function automatic logic [5:0] outs();
    return {active, smpl_req, underrun, sclk, lrclk, sdata};
  endfunction

  vec_t vec[8];
  logic req, und;
  int   nz_cnt;

  initial begin
    vec[0] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0};
    vec[1] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b1, 1'b0};
    vec[2] = '{16'h7FFF, 16'hFFFF, 16'h7FFF, 16'hFFFF, 1'b1, 1'b0};
    vec[3] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b1, 1'b0};
    vec[4] = '{16'hA5C3, 16'h5A3C, 16'hA5C3, 16'h5A3C, 1'b1, 1'b0};
    vec[5] = '{16'h0000, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0};
    vec[6] = '{16'hFEDC, 16'h0000, 16'hFEDC, 16'h0000, 1'b1, 1'b0};
    vec[7] = '{16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 1'b1, 1'b0};

    rst_n = 1'b0; lft_smpl = '0; rht_smpl = '0; smpl_vld = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 32'(outs()), 0);
    rst_n = 1'b1;
    nz_cnt = 0;
    repeat (20) begin tick(); if (outs() != 6'b0) nz_cnt++; end
    chk("idle_quiet", nz_cnt, 0);

    // basic frame with hand-placed timing probes
    drive_pair(16'hA5C3, 16'h3C5A);
    chk("entry_outputs", 32'(outs()), 32'(6'b110000));
    repeat (7) tick();
    chk("sclk_low_half", 32'(sclk), 0);
    tick();
    chk("sclk_rise_mid", 32'(sclk), 1);
    repeat (8) tick();
    chk("left_msb_slot1", 32'({sclk, sdata}), 32'(2'b01));
    repeat (495) tick();
    chk("lrclk_bit31", 32'(lrclk), 0);
    tick();
    chk("lrclk_bit32", 32'({lrclk, sdata}), 32'(2'b10));
    repeat (16) tick();
    chk("right_msb_slot33", 32'(sdata), 0);
    repeat (32) tick();
    chk("right_b13_slot35", 32'(sdata), 1);
    repeat (464) tick();
    chk("frame2_start_underrun", 32'({smpl_req, underrun}), 32'(2'b01));
    pop_frame("basic", 16'hA5C3, 16'h3C5A, 1'b0);

    // streaming from the vector table, starting inside the mute frame
    repeat (100) tick();
    drive_pair(vec[0].l, vec[0].r);
    for (int i = 0; i < 8; i++) begin
      wait_fs(req, und);
      chk($sformatf("stream%0d_req", i), 32'(req), 32'(vec[i].exp_req));
      chk($sformatf("stream%0d_und", i), 32'(und), 32'(vec[i].exp_und));
      if (i == 0) pop_frame("mute", 16'h0000, 16'h0000, 1'b1);
      else pop_frame($sformatf("stream%0d", i-1), vec[i-1].exp_l, vec[i-1].exp_r, 1'b0);
      tick();
      if (i < 7) drive_pair(vec[i+1].l, vec[i+1].r);
    end
    wait_fs(req, und);
    chk("stream_end_flags", 32'({req, und}), 32'(2'b01));
    pop_frame("stream7", vec[7].exp_l, vec[7].exp_r, 1'b0);

    // two pairs in one frame: newest wins
    repeat (50) tick();
    drive_pair(16'h1111, 16'h1111);
    repeat (200) tick();
    drive_pair(16'h2222, 16'h2222);
    wait_fs(req, und);
    chk("overwrite_flags", 32'({req, und}), 32'(2'b10));
    pop_frame("mute2", 16'h0000, 16'h0000, 1'b1);
    wait_fs(req, und);
    chk("overwrite_end_flags", 32'({req, und}), 32'(2'b01));
    pop_frame("overwrite", 16'h2222, 16'h2222, 1'b0);

    // pair arriving in the boundary cycle with holding empty
    repeat (1023) tick();
    drive_pair(16'hBEEF, 16'h1357);
    chk("bypass_flags", 32'({smpl_req, underrun}), 32'(2'b10));
    pop_frame("mute3", 16'h0000, 16'h0000, 1'b1);
    // pair arriving in the boundary cycle with holding valid
    repeat (100) tick();
    drive_pair(16'h4444, 16'h4444);
    repeat (922) tick();
    drive_pair(16'h5555, 16'h5555);
    chk("simul_held_flags", 32'({smpl_req, underrun}), 32'(2'b10));
    pop_frame("bypass", 16'hBEEF, 16'h1357, 1'b0);
    wait_fs(req, und);
    chk("held_next_flags", 32'({req, und}), 32'(2'b10));
    pop_frame("held_a", 16'h4444, 16'h4444, 1'b0);
    wait_fs(req, und);
    chk("held_end_flags", 32'({req, und}), 32'(2'b01));
    pop_frame("held_b", 16'h5555, 16'h5555, 1'b0);

    // reset in the middle of bit 20 of a mute frame
    repeat (20*DIV + 3) tick();
    chk("pre_reset_active", 32'(active), 1);
    #3 rst_n = 1'b0;
    #1 chk("midframe_reset_outputs", 32'(outs()), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    nz_cnt = 0;
    repeat (40) begin tick(); if (outs() != 6'b0) nz_cnt++; end
    chk("post_reset_quiet", nz_cnt, 0);
    drive_pair(16'h8421, 16'hC001);
    chk("restart_entry", 32'(outs()), 32'(6'b110000));
    repeat (DIV) tick();
    chk("restart_left_msb", 32'(sdata), 1);
    wait_fs(req, und);
    chk("restart_end_flags", 32'({req, und}), 32'(2'b01));
    pop_frame("restart", 16'h8421, 16'hC001, 1'b0);

    chk("leftover_frames", fq.size(), 0);
    chk("sclk_timing_errors", sclk_err, 0);
    chk("lrclk_period_errors", lr_err, 0);
    chk("lrclk_rises_seen", 32'(n_lr >= 10), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
